mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for a multi-cycle multiplier: one op in flight,
// result held for the writeback handshake, with flush squashing and a sticky watchdog.
module mul_issue_ctrl #(
    parameter int WREG_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_rs1_i,
    input  logic [31:0]       req_rs2_i,
    input  logic [1:0]        req_op_i,
    input  logic [WREG_W-1:0] req_wreg_i,
    input  logic              flush_i,

    output logic              mul_start_o,
    output logic [31:0]       mul_rs1_o,
    output logic [31:0]       mul_rs2_o,
    output logic [1:0]        mul_op_o,
    input  logic              mul_done_i,
    input  logic [31:0]       mul_result_i,

    output logic              wb_valid_o,
    output logic [31:0]       wb_data_o,
    output logic [WREG_W-1:0] wb_wreg_o,
    input  logic              wb_ack_i,

    output logic              err_o
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_squash;
    logic                w_nextSquash;
    logic [WD_W-1:0]     r_wdog;
    logic [WD_W-1:0]     w_nextWdog;
    logic                r_err;
    logic                w_nextErr;
    logic [31:0]         r_wbData;
    logic [WREG_W-1:0]   r_wbWreg;
    logic                w_ready;
    logic                w_accept;
    logic                w_capture;

    // rst_n gates accept so no multiplier start can escape while reset is held.
    always_comb begin
        w_ready  = (r_state == IDLE) | ((r_state == HOLD) & wb_ack_i);
        w_accept = rst_n & req_valid_i & w_ready & ~flush_i;
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextSquash = r_squash;
        w_nextWdog   = r_wdog;
        w_nextErr    = r_err;
        w_capture    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState  = BUSY;
                    w_nextWdog   = '0;
                    w_nextSquash = 1'b0;
                end
            end

            BUSY: begin
                if (mul_done_i) begin
                    if (flush_i | r_squash) begin
                        w_nextState  = IDLE;
                        w_nextSquash = 1'b0;
                    end else begin
                        w_capture   = 1'b1;
                        w_nextState = HOLD;
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_nextState  = IDLE;
                    w_nextErr    = 1'b1;
                    w_nextSquash = 1'b0;
                    w_nextWdog   = '0;
                end else begin
                    w_nextWdog = r_wdog + 1'b1;
                    if (flush_i) begin
                        w_nextSquash = 1'b1;
                    end
                end
            end

            HOLD: begin
                // A flush with ack is treated as a completed handshake; accept is already blocked.
                if (flush_i) begin
                    w_nextState = IDLE;
                end else if (wb_ack_i) begin
                    if (w_accept) begin
                        w_nextState  = BUSY;
                        w_nextWdog   = '0;
                        w_nextSquash = 1'b0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end

            default: begin
                w_nextState  = IDLE;
                w_nextSquash = 1'b0;
                w_nextWdog   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
            r_wdog   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_squash <= w_nextSquash;
            r_wdog   <= w_nextWdog;
            r_err    <= w_nextErr;
        end
    end

    // Writeback payload only changes on capture/accept, so it is stable while HOLD waits for ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbData <= '0;
            r_wbWreg <= '0;
        end else begin
            if (w_capture) begin
                r_wbData <= mul_result_i;
            end
            if (w_accept) begin
                r_wbWreg <= req_wreg_i;
            end
        end
    end

    always_comb begin
        req_ready_o = w_ready;
        mul_start_o = w_accept;
        mul_rs1_o   = req_rs1_i;
        mul_rs2_o   = req_rs2_i;
        mul_op_o    = req_op_i;
        wb_valid_o  = (r_state == HOLD);
        wb_data_o   = r_wbData;
        wb_wreg_o   = r_wbWreg;
        err_o       = r_err;
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: a scoreboard queue holds the expected
// writeback for each accepted op and is popped when wb_valid_o appears.
module tb_mul_issue_ctrl;

    localparam int TB_WREG_W  = 5;
    localparam int TB_TIMEOUT = 15;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [31:0]          req_rs1_i;
    logic [31:0]          req_rs2_i;
    logic [1:0]           req_op_i;
    logic [TB_WREG_W-1:0] req_wreg_i;
    logic                 flush_i;
    logic                 mul_start_o;
    logic [31:0]          mul_rs1_o;
    logic [31:0]          mul_rs2_o;
    logic [1:0]           mul_op_o;
    logic                 mul_done_i;
    logic [31:0]          mul_result_i;
    logic                 wb_valid_o;
    logic [31:0]          wb_data_o;
    logic [TB_WREG_W-1:0] wb_wreg_o;
    logic                 wb_ack_i;
    logic                 err_o;

    typedef struct {
        logic [31:0]          data;
        logic [TB_WREG_W-1:0] wreg;
    } exp_t;

    exp_t        sbQ[$];
    int          checkCount;
    int          errorCount;
    logic [31:0] inflightRes;

    mul_issue_ctrl #(
        .WREG_W  (TB_WREG_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_rs1_i    (req_rs1_i),
        .req_rs2_i    (req_rs2_i),
        .req_op_i     (req_op_i),
        .req_wreg_i   (req_wreg_i),
        .flush_i      (flush_i),
        .mul_start_o  (mul_start_o),
        .mul_rs1_o    (mul_rs1_o),
        .mul_rs2_o    (mul_rs2_o),
        .mul_op_o     (mul_op_o),
        .mul_done_i   (mul_done_i),
        .mul_result_i (mul_result_i),
        .wb_valid_o   (wb_valid_o),
        .wb_data_o    (wb_data_o),
        .wb_wreg_o    (wb_wreg_o),
        .wb_ack_i     (wb_ack_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: low 32 bits of the product.
    function automatic logic [31:0] mulModel(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [TB_WREG_W-1:0] wreg);
        req_valid_i = v;
        req_op_i    = op;
        req_rs1_i   = rs1;
        req_rs2_i   = rs2;
        req_wreg_i  = wreg;
    endtask

    task automatic driveMul(input logic done, input logic [31:0] res);
        mul_done_i   = done;
        mul_result_i = res;
    endtask

    // Present an op that must be accepted this cycle; queue its writeback if one is expected.
    task automatic issueOp(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [TB_WREG_W-1:0] wreg,
                           input logic expectWb);
        exp_t e;
        applyStimulus(1'b1, op, rs1, rs2, wreg);
        #1;
        inflightRes = mulModel(rs1, rs2);
        checkOutput({tag, "_start"}, mul_start_o, 1);
        checkOutput({tag, "_rs1"}, mul_rs1_o, rs1);
        checkOutput({tag, "_rs2"}, mul_rs2_o, rs2);
        checkOutput({tag, "_op"}, 32'(mul_op_o), 32'(op));
        if (expectWb) begin
            e.data = inflightRes;
            e.wreg = wreg;
            sbQ.push_back(e);
        end
    endtask

    task automatic popCheck(input string tag);
        exp_t e;
        checkOutput({tag, "_wbvalid"}, wb_valid_o, 1);
        checkOutput({tag, "_sbnonempty"}, 32'(sbQ.size() != 0), 1);
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, "_wbdata"}, wb_data_o, e.data);
            checkOutput({tag, "_wbwreg"}, 32'(wb_wreg_o), 32'(e.wreg));
        end
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        inflightRes = '0;
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        wb_ack_i    = 1'b0;
        driveMul(1'b0, 32'h0);
        applyStimulus(1'b1, 2'b01, 32'h1, 32'h2, 5'd1);

        // Reset state, with a request present that must not start the multiplier
        #2;
        checkOutput("rst_start", mul_start_o, 0);
        checkOutput("rst_wbvalid", wb_valid_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_wbdata", wb_data_o, 0);
        checkOutput("rst_wbwreg", 32'(wb_wreg_o), 0);
        checkOutput("rst_ready", req_ready_o, 1);
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic op: wb_valid two cycles after accept
        issueOp("t1", 2'b01, 32'd7, 32'hFFFFFFFD, 5'd4, 1'b1);
        checkOutput("t1_ready", req_ready_o, 1);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        driveMul(1'b1, inflightRes);
        #1;
        checkOutput("t1_busy_wbvalid", wb_valid_o, 0);
        checkOutput("t1_busy_ready", req_ready_o, 0);
        checkOutput("t1_busy_start", mul_start_o, 0);
        tick();
        driveMul(1'b0, 32'hDEADBEEF);
        #1;
        popCheck("t1");
        checkOutput("t1_const", wb_data_o, 32'hFFFFFFEB);

        // Stall in HOLD for 5 cycles; stray done and pending request must be ignored
        applyStimulus(1'b1, 2'b10, 32'h1234, 32'h10, 5'd9);
        driveMul(1'b1, 32'h55AA55AA);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t2_hold_start", mul_start_o, 0);
            checkOutput("t2_hold_ready", req_ready_o, 0);
            checkOutput("t2_hold_wbvalid", wb_valid_o, 1);
            checkOutput("t2_hold_data", wb_data_o, 32'hFFFFFFEB);
            checkOutput("t2_hold_wreg", 32'(wb_wreg_o), 4);
            tick();
        end
        driveMul(1'b0, 32'h0);
        wb_ack_i = 1'b1;
        issueOp("t2", 2'b10, 32'h1234, 32'h10, 5'd9, 1'b1);
        checkOutput("t2_b2b_ready", req_ready_o, 1);
        tick();
        wb_ack_i = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        driveMul(1'b1, inflightRes);
        #1;
        checkOutput("t2_busy_wbvalid", wb_valid_o, 0);
        checkOutput("t2_busy_ready", req_ready_o, 0);
        tick();
        driveMul(1'b0, 32'h0);
        #1;
        popCheck("t2");
        wb_ack_i = 1'b1;
        #1;
        checkOutput("t2_ack_ready", req_ready_o, 1);
        tick();
        wb_ack_i = 1'b0;
        #1;
        checkOutput("t2_idle_wbvalid", wb_valid_o, 0);
        checkOutput("t2_idle_ready", req_ready_o, 1);

        // Flush one cycle after accept, done arrives later
        issueOp("t3", 2'b00, 32'd5, 32'd6, 5'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        flush_i = 1'b1;
        #1;
        checkOutput("t3_flush_start", mul_start_o, 0);
        checkOutput("t3_flush_ready", req_ready_o, 0);
        tick();
        flush_i = 1'b0;
        driveMul(1'b1, inflightRes);
        #1;
        checkOutput("t3_sq_wbvalid", wb_valid_o, 0);
        tick();
        driveMul(1'b0, 32'h0);
        #1;
        checkOutput("t3_idle_wbvalid", wb_valid_o, 0);
        checkOutput("t3_idle_ready", req_ready_o, 1);
        tick();
        checkOutput("t3_late_wbvalid", wb_valid_o, 0);

        // Flush and done in the same BUSY cycle
        issueOp("t4", 2'b11, 32'd9, 32'd9, 5'd7, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        flush_i = 1'b1;
        driveMul(1'b1, inflightRes);
        #1;
        tick();
        flush_i = 1'b0;
        driveMul(1'b0, 32'h0);
        #1;
        checkOutput("t4_wbvalid", wb_valid_o, 0);
        checkOutput("t4_ready", req_ready_o, 1);

        // Flush in HOLD together with ack and a pending request
        issueOp("t5", 2'b01, 32'd3, 32'd11, 5'd12, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        driveMul(1'b1, inflightRes);
        #1;
        tick();
        driveMul(1'b0, 32'h0);
        #1;
        popCheck("t5");
        flush_i  = 1'b1;
        wb_ack_i = 1'b1;
        applyStimulus(1'b1, 2'b01, 32'd1, 32'd1, 5'd13);
        #1;
        checkOutput("t5_flush_start", mul_start_o, 0);
        checkOutput("t5_flush_ready", req_ready_o, 1);
        tick();
        flush_i  = 1'b0;
        wb_ack_i = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        #1;
        checkOutput("t5_idle_wbvalid", wb_valid_o, 0);
        checkOutput("t5_idle_ready", req_ready_o, 1);

        // Watchdog: no done ever, err after TIMEOUT BUSY cycles
        issueOp("t6", 2'b01, 32'd2, 32'd2, 5'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        #1;
        checkOutput("t6_wd_err", err_o, 0);
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            tick();
            checkOutput("t6_wd_err", err_o, 0);
            checkOutput("t6_wd_ready", req_ready_o, 0);
        end
        tick();
        checkOutput("t6_to_err", err_o, 1);
        checkOutput("t6_to_ready", req_ready_o, 1);
        checkOutput("t6_to_wbvalid", wb_valid_o, 0);
        issueOp("t6b", 2'b10, 32'd100, 32'd200, 5'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        driveMul(1'b1, inflightRes);
        #1;
        tick();
        driveMul(1'b0, 32'h0);
        #1;
        popCheck("t6b");
        checkOutput("t6b_err_sticky", err_o, 1);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        #1;
        checkOutput("t6b_err_sticky2", err_o, 1);
        checkOutput("t6b_ready", req_ready_o, 1);

        // Asynchronous reset while holding a result; late done ignored
        issueOp("t7", 2'b01, 32'hFFFF, 32'hFFFF, 5'd31, 1'b1);
        tick();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        driveMul(1'b1, inflightRes);
        #1;
        tick();
        driveMul(1'b0, 32'h0);
        #1;
        popCheck("t7");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_wbvalid", wb_valid_o, 0);
        checkOutput("t7_rst_wbdata", wb_data_o, 0);
        checkOutput("t7_rst_wbwreg", 32'(wb_wreg_o), 0);
        checkOutput("t7_rst_err", err_o, 0);
        checkOutput("t7_rst_start", mul_start_o, 0);
        #2;
        rst_n = 1'b1;
        driveMul(1'b1, 32'h00000BAD);
        tick();
        driveMul(1'b0, 32'h0);
        #1;
        checkOutput("t7_late_wbvalid", wb_valid_o, 0);
        checkOutput("t7_late_ready", req_ready_o, 1);
        tick();
        checkOutput("t7_late_wbvalid2", wb_valid_o, 0);

        checkOutput("sb_drained", 32'(sbQ.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
